alu_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters (e.g. issue pipe, branch unit, AGU).

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_arbiter_alu.sv | 52 +++++
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and small decode helpers used by the arbiter and its ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctrls_t;

  function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // Only the compare-style operations produce a meaningful branch flag.
  function automatic logic alu_ctrl_has_bflag(input logic [3:0] ctrl);
    case (ctrl)
      ALU_SUB, ALU_SLT, ALU_SLTU: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; b_flag is equality for SUB, signed/unsigned less-than for SLT/SLTU.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            ctrl,
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  b_flag
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = in_2[4:0];
  assign lt_s  = $signed(in_1) < $signed(in_2);
  assign lt_u  = in_1 < in_2;

  always_comb begin
    result = '0;
    b_flag = 1'b0;
    case (ctrl)
      ALU_ADD:  result = in_1 + in_2;
      ALU_SUB: begin
        result = in_1 - in_2;
        b_flag = (in_1 == in_2);
      end
      ALU_SLL:  result = in_1 << shamt;
      ALU_SLT: begin
        result = DATA_WIDTH'(lt_s);
        b_flag = lt_s;
      end
      ALU_SLTU: begin
        result = DATA_WIDTH'(lt_u);
        b_flag = lt_u;
      end
      ALU_XOR:  result = in_1 ^ in_2;
      ALU_SRL:  result = in_1 >> shamt;
      ALU_SRA:  result = $signed(in_1) >>> shamt;
      ALU_OR:   result = in_1 | in_2;
      ALU_AND:  result = in_1 & in_2;
      default: begin
        result = '0;
        b_flag = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU across NUM_REQ requesters with operand and result stages.
// Define ALU_ARB_STATS_EN to add per-requester grant counters and an error counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*4-1:0]          req_ctrl,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in_2,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_b_flag,
  output logic                          rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt,
  output logic [15:0]                   err_cnt
`endif
);

  logic [3:0]            ctrl_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] in1_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] in2_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign ctrl_arr[gi] = req_ctrl[4*gi +: 4];
    assign in1_arr[gi]  = req_in_1[DATA_WIDTH*gi +: DATA_WIDTH];
    assign in2_arr[gi]  = req_in_2[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, winner, arb_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  found, hs, s1_free, s2_free;
  logic                  s1_valid_q;
  logic [3:0]            s1_ctrl_q;
  logic [DATA_WIDTH-1:0] s1_in1_q, s1_in2_q;
  logic [ID_W-1:0]       s1_id_q;
  logic                  rsp_valid_q, rsp_b_flag_q, rsp_err_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [DATA_WIDTH-1:0] alu_result, s2_result_d;
  logic                  alu_b_flag, s2_b_flag_d, s2_err_d, ctrl_legal;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant   = '0;
    winner  = '0;
    found   = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[arb_idx]) begin
        grant[arb_idx] = 1'b1;
        winner         = arb_idx;
        found          = 1'b1;
      end
    end
  end

  assign s2_free   = !rsp_valid_q || rsp_ready;
  assign s1_free   = !s1_valid_q || s2_free;
  assign req_ready = grant & {NUM_REQ{s1_free && rst_n}};
  assign hs        = |(req_valid & req_ready);
  assign rr_ptr_d  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  alu_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .ctrl  (s1_ctrl_q),
    .in_1  (s1_in1_q),
    .in_2  (s1_in2_q),
    .result(alu_result),
    .b_flag(alu_b_flag)
  );

  assign ctrl_legal  = alu_ctrl_legal(s1_ctrl_q);
  assign s2_result_d = ctrl_legal ? alu_result : '0;
  assign s2_b_flag_d = ctrl_legal && alu_ctrl_has_bflag(s1_ctrl_q) && alu_b_flag;
  assign s2_err_d    = !ctrl_legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_ctrl_q    <= '0;
      s1_in1_q     <= '0;
      s1_in2_q     <= '0;
      s1_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_b_flag_q <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr_q  <= rr_ptr_d;
        s1_ctrl_q <= ctrl_arr[winner];
        s1_in1_q  <= in1_arr[winner];
        s1_in2_q  <= in2_arr[winner];
        s1_id_q   <= winner;
      end
      if (s1_free) s1_valid_q <= hs;
      if (s2_free) rsp_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_free) begin
        rsp_id_q     <= s1_id_q;
        rsp_result_q <= s2_result_d;
        rsp_b_flag_q <= s2_b_flag_d;
        rsp_err_q    <= s2_err_d;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_b_flag = rsp_b_flag_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] err_cnt_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (req_valid[gi] && req_ready[gi] && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt[16*gi +: 16] = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (s1_valid_q && s2_free && s2_err_d && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NUM_REQ=2, DATA_WIDTH=32).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_in_1;
  logic [63:0] req_in_2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_b_flag;
  logic        rsp_err;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_in_1  (req_in_1),
    .req_in_2  (req_in_2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_b_flag(rsp_b_flag),
    .rsp_err   (rsp_err)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid[i]         = v;
    req_ctrl[4*i +: 4]   = c;
    req_in_1[32*i +: 32] = a;
    req_in_2[32*i +: 32] = b;
  endtask

  // Single operation with rsp_ready=1: accept, then check the response one cycle later.
  task automatic issue(input string tag, input int i, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_bf, input logic exp_err);
    int n = 0;
    drive(i, 1'b1, c, a, b);
    #1;
    while (!req_ready[i] && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 64'(n < 10), 64'd1);
    tick();
    req_valid[i] = 1'b0;
    tick();
    check({tag, "_valid"},  64'(rsp_valid),  64'd1);
    check({tag, "_id"},     64'(rsp_id),     64'(i));
    check({tag, "_result"}, 64'(rsp_result), 64'(exp_r));
    check({tag, "_bflag"},  64'(rsp_b_flag), 64'(exp_bf));
    check({tag, "_err"},    64'(rsp_err),    64'(exp_err));
    $display("op %s req%0d ctrl=%b a=%h b=%h -> result=%h bflag=%b err=%b",
             tag, i, c, a, b, rsp_result, rsp_b_flag, rsp_err);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_ctrl  = '0;
    req_in_1  = '0;
    req_in_2  = '0;
    drive(0, 1'b1, 4'b0000, 32'd1, 32'd1);
    tick();
    tick();
    check("rst_ready",  64'(req_ready),  64'd0);
    check("rst_valid",  64'(rsp_valid),  64'd0);
    check("rst_id",     64'(rsp_id),     64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_bflag",  64'(rsp_b_flag), 64'd0);
    check("rst_err",    64'(rsp_err),    64'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // 1: single ADD
    issue("add", 0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    // 2: both requesters valid from reset, grants alternate
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 1'b1, 4'b1000, 32'd9, 32'd9);
    drive(1, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd2);
    #1;
    check("t2_grant_a", 64'(req_ready), 64'b01);
    tick();
    check("t2_grant_b", 64'(req_ready), 64'b10);
    check("t2_s1_only", 64'(rsp_valid), 64'd0);
    tick();
    check("t2_r0_valid",  64'(rsp_valid),  64'd1);
    check("t2_r0_id",     64'(rsp_id),     64'd0);
    check("t2_r0_result", 64'(rsp_result), 64'd0);
    check("t2_r0_bflag",  64'(rsp_b_flag), 64'd1);
    check("t2_grant_c",   64'(req_ready),  64'b01);
    $display("op t2 id=%0d result=%h bflag=%b", rsp_id, rsp_result, rsp_b_flag);
    tick();
    check("t2_r1_id",     64'(rsp_id),     64'd1);
    check("t2_r1_result", 64'(rsp_result), 64'd1);
    check("t2_r1_bflag",  64'(rsp_b_flag), 64'd1);
    check("t2_grant_d",   64'(req_ready),  64'b10);
    $display("op t2 id=%0d result=%h bflag=%b", rsp_id, rsp_result, rsp_b_flag);
    req_valid = '0;
    tick();
    check("t2_r2_id",     64'(rsp_id),     64'd0);
    check("t2_r2_result", 64'(rsp_result), 64'd0);
    $display("op t2 id=%0d result=%h bflag=%b", rsp_id, rsp_result, rsp_b_flag);
    tick();
    check("t2_drained", 64'(rsp_valid), 64'd0);

    // 3: backpressure while req0 streams ADDs
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'b0000, 32'd1, 32'd100);
    #1;
    check("t3_rdy_a", 64'(req_ready), 64'b01);
    tick();
    drive(0, 1'b1, 4'b0000, 32'd2, 32'd100);
    #1;
    check("t3_rdy_b", 64'(req_ready), 64'b01);
    check("t3_empty", 64'(rsp_valid), 64'd0);
    tick();
    drive(0, 1'b1, 4'b0000, 32'd3, 32'd100);
    #1;
    check("t3_hold_valid", 64'(rsp_valid),  64'd1);
    check("t3_hold_res_a", 64'(rsp_result), 64'd101);
    check("t3_rdy_c",      64'(req_ready),  64'b00);
    tick();
    check("t3_hold_res_b", 64'(rsp_result), 64'd101);
    check("t3_rdy_d",      64'(req_ready),  64'b00);
    tick();
    check("t3_hold_res_c", 64'(rsp_result), 64'd101);
    check("t3_hold_id",    64'(rsp_id),     64'd0);
    rsp_ready = 1'b1;
    #1;
    check("t3_rdy_e", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    check("t3_res_2", 64'(rsp_result), 64'd102);
    $display("op t3 result=%0d", rsp_result);
    tick();
    check("t3_res_3",   64'(rsp_result), 64'd103);
    check("t3_valid_3", 64'(rsp_valid),  64'd1);
    $display("op t3 result=%0d", rsp_result);
    tick();
    check("t3_drained", 64'(rsp_valid), 64'd0);

    // 4/5 and extra single-op vectors
    issue("illegal",  1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    issue("illegal2", 0, 4'b1001, 32'd7, 32'd3, 32'h0, 1'b0, 1'b1);
    issue("sra",      0, 4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0);
    issue("srl",      1, 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0);
    issue("sltu",     1, 4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    issue("slt_f",    0, 4'b0010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue("sub_ne",   0, 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue("sll",      1, 4'b0001, 32'd3, 32'h0000_0021, 32'd6, 1'b0, 1'b0);
    issue("xor",      0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    issue("and",      1, 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    issue("or",       0, 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    issue("add_wrap", 1, 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
`ifdef ALU_ARB_STATS_EN
    check("stats_err_cnt", 64'(err_cnt), 64'd2);
`endif

    // 6: reset with S1 and S2 both full
    rsp_ready = 1'b0;
    drive(0, 1'b1, 4'b0000, 32'd1, 32'd2);
    tick();
    drive(0, 1'b1, 4'b0000, 32'd3, 32'd4);
    tick();
    req_valid = '0;
    check("t6_full_valid", 64'(rsp_valid),  64'd1);
    check("t6_full_res",   64'(rsp_result), 64'd3);
    drive(0, 1'b1, 4'b0000, 32'd10, 32'd20);
    drive(1, 1'b1, 4'b0000, 32'd1, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_ready",  64'(req_ready),  64'd0);
    check("t6_rst_valid",  64'(rsp_valid),  64'd0);
    check("t6_rst_result", 64'(rsp_result), 64'd0);
    check("t6_rst_id",     64'(rsp_id),     64'd0);
`ifdef ALU_ARB_STATS_EN
    check("t6_grant_cnt", 64'(grant_cnt), 64'd0);
    check("t6_err_cnt",   64'(err_cnt),   64'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("t6_no_stale_a", 64'(rsp_valid), 64'd0);
    tick();
    check("t6_no_stale_b", 64'(rsp_valid), 64'd0);
    drive(0, 1'b1, 4'b0000, 32'd10, 32'd20);
    drive(1, 1'b1, 4'b0000, 32'd1, 32'd1);
    #1;
    check("t6_first_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    tick();
    check("t6_post_valid", 64'(rsp_valid),  64'd1);
    check("t6_post_id",    64'(rsp_id),     64'd0);
    check("t6_post_res",   64'(rsp_result), 64'd30);
    $display("op t6 id=%0d result=%0d", rsp_id, rsp_result);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
